prga: RTL and testbench

// - RC4 pseudo-random generation stage: reads S memory left by init+ksa, swaps S[i]/S[j] per byte, XORs keystream with ciphertext.
// - Reads length-prefixed ciphertext memory (ct[0]=len, ct[1..len]=bytes); writes plaintext memory in the same format.
// - Sits after ksa under the top-level sequencer; shares the en/rdy handshake and owns the S-memory port only while busy.

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/prga.sv | 148 ++++++++++++++
 tb/tb_prga.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 types: byte type, PRGA state encoding and the ciphertext length address.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_LEN = 4'd1,
    LEN    = 4'd2,
    RD_I   = 4'd3,
    GET_SI = 4'd4,
    GET_SJ = 4'd5,
    WR_J   = 4'd6,
    RD_PAD = 4'd7,
    XOR    = 4'd8
  } prga_state_t;

  localparam byte_t LEN_ADDR = 8'd0;

endpackage

// File: rtl/prga.sv
// RC4 PRGA stage: swaps S[i]/S[j] per byte and XORs the keystream into a length-prefixed message.
// Optional pad tap (pad_out/pad_vld) is compiled in when PRGA_PAD_TAP_EN is defined.
module prga
  import rc4_pkg::*;
#(
  parameter int MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
`ifdef PRGA_PAD_TAP_EN
  ,
  output logic [7:0]        pad_out,
  output logic              pad_vld
`endif
);

  prga_state_t state;
  byte_t       i, j, k, len, si, sj;

  // The S[i+1] read for the next byte is issued from LEN and XOR, so RD_I is
  // never entered and each byte costs five cycles.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RD_LEN;
            i     <= '0;
            j     <= '0;
          end
        end
        RD_LEN: state <= LEN;
        LEN: begin
          len <= ct_rddata;
          k   <= 8'd1;
          if (ct_rddata == 8'd0) begin
            state <= IDLE;
          end else begin
            i     <= i + 8'd1;
            state <= GET_SI;
          end
        end
        GET_SI: begin
          si    <= s_rddata;
          j     <= j + s_rddata;
          state <= GET_SJ;
        end
        GET_SJ: begin
          sj    <= s_rddata;
          state <= WR_J;
        end
        WR_J:   state <= RD_PAD;
        RD_PAD: state <= XOR;
        XOR: begin
          if (k == len) begin
            state <= IDLE;
          end else begin
            k     <= k + 8'd1;
            i     <= i + 8'd1;
            state <= GET_SI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      IDLE:   rdy = 1'b1;
      RD_LEN: ct_addr = MSG_AW'(LEN_ADDR);
      LEN: begin
        pt_addr   = MSG_AW'(LEN_ADDR);
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        s_addr    = i + 8'd1;
      end
      GET_SI: s_addr = j + s_rddata;
      GET_SJ: begin
        // S[i] takes S[j]; S[j] takes the saved S[i] next cycle (i==j writes the same value twice)
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      RD_PAD: begin
        s_addr  = si + sj;
        ct_addr = MSG_AW'(k);
      end
      XOR: begin
        pt_addr   = MSG_AW'(k);
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        s_addr    = i + 8'd1;
      end
      default: ;
    endcase
  end

`ifdef PRGA_PAD_TAP_EN
  byte_t pad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_q <= '0;
    end else if (state == XOR) begin
      pad_q <= s_rddata;
    end
  end

  assign pad_out = (state == XOR) ? s_rddata : pad_q;
  assign pad_vld = (state == XOR);
`endif

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: 1-cycle RAM models for S/ct/pt and a software RC4 reference.
module tb_prga;
  import rc4_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;
`ifdef PRGA_PAD_TAP_EN
  logic [7:0] pad_out;
  logic       pad_vld;
`endif

  int checks = 0;
  int errors = 0;

  prga #(.MSG_AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
`ifdef PRGA_PAD_TAP_EN
    ,
    .pad_out   (pad_out),
    .pad_vld   (pad_vld)
`endif
  );

  always #5 clk = ~clk;

  byte_t s_mem [256];
  byte_t ct_mem[256];
  byte_t pt_mem[256];
  int    s_wr_cnt, pt_wr_cnt;

  always @(posedge clk) begin
    if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
      s_wr_cnt++;
    end
    if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      pt_wr_cnt++;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  byte_t ms [256];
  byte_t mpt[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook RC4 keystream over the model copy of S.
  task automatic model_run();
    int    ii = 0;
    int    jj = 0;
    byte_t t;
    mpt[0] = ct_mem[0];
    for (int n = 1; n <= int'(ct_mem[0]); n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + ms[ii]) % 256;
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
      mpt[n] = ms[(ms[ii] + ms[jj]) % 256] ^ ct_mem[n];
    end
  endtask

  task automatic s_identity();
    for (int a = 0; a < 256; a++) s_mem[a] = byte_t'(a);
  endtask

  // held=1 keeps en high for several busy cycles and re-pulses it mid-run.
  task automatic run_msg(input bit held, output int busy);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    busy = 0;
    while (!rdy && busy < 2000) begin
      busy++;
      en = held && (busy < 4 || busy == 6);
      @(negedge clk);
    end
    en = 1'b0;
    check("timeout", 32'(busy < 2000), 32'd1);
  endtask

  task automatic compare_all(input string tag);
    int bad_pt = 0;
    int bad_s  = 0;
    for (int a = 0; a <= int'(ct_mem[0]); a++) if (pt_mem[a] !== mpt[a]) bad_pt++;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== ms[a]) bad_s++;
    check({tag, "_pt_vs_model"}, 32'(bad_pt), 32'd0);
    check({tag, "_s_vs_model"}, 32'(bad_s), 32'd0);
  endtask

  initial begin
    int    busy;
    int    r;
    byte_t t;

    rst = 1'b1;
    en  = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ct_mem[a] = '0;
      pt_mem[a] = 8'hEE;
    end
    s_identity();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s_wr_cnt  = 0;
    pt_wr_cnt = 0;

    // Reset and idle behaviour
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_ct_addr", ct_addr, 32'd0);
    check("rst_pt_addr", pt_addr, 32'd0);
    for (int c = 0; c < 10; c++) begin
      check("idle_rdy", rdy, 32'd1);
      check("idle_s_wren", s_wren, 32'd0);
      check("idle_pt_wren", pt_wren, 32'd0);
      @(negedge clk);
    end
    check("idle_writes", 32'(s_wr_cnt + pt_wr_cnt), 32'd0);

    // Single byte over identity S
    s_identity();
    ms = s_mem;
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h00;
    model_run();
    run_msg(1'b0, busy);
    check("len1_busy", 32'(busy), 32'd7);
    check("len1_pt0", pt_mem[0], 32'd1);
    check("len1_pt1", pt_mem[1], 32'h02);
    compare_all("len1");

    // Two bytes over identity S
    s_identity();
    ms = s_mem;
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h00; ct_mem[2] = 8'h00;
    model_run();
    run_msg(1'b0, busy);
    check("len2_busy", 32'(busy), 32'd12);
    check("len2_pt1", pt_mem[1], 32'h02);
    check("len2_pt2", pt_mem[2], 32'h05);
    check("len2_s2", s_mem[2], 32'd3);
    check("len2_s3", s_mem[3], 32'd2);
    compare_all("len2");

    // Empty message
    pt_mem[0] = 8'hAA;
    ct_mem[0] = 8'd0;
    s_wr_cnt  = 0;
    pt_wr_cnt = 0;
    run_msg(1'b0, busy);
    check("len0_busy", 32'(busy), 32'd2);
    check("len0_pt0", pt_mem[0], 32'd0);
    check("len0_s_writes", 32'(s_wr_cnt), 32'd0);
    check("len0_pt_writes", 32'(pt_wr_cnt), 32'd1);

    // en held and re-pulsed while busy
    s_identity();
    for (int a = 0; a < 4; a++) pt_mem[a] = 8'hEE;
    ms = s_mem;
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h00; ct_mem[2] = 8'h00;
    model_run();
    s_wr_cnt = 0;
    run_msg(1'b1, busy);
    check("held_busy", 32'(busy), 32'd12);
    check("held_pt2", pt_mem[2], 32'h05);
    check("held_s_writes", 32'(s_wr_cnt), 32'd4);
    compare_all("held");
    repeat (2) @(negedge clk);
    check("held_stays_idle", rdy, 32'd1);

    // Random permutation, maximum length
    s_identity();
    for (int a = 255; a > 0; a--) begin
      r = int'($urandom_range(a, 0));
      t = s_mem[a]; s_mem[a] = s_mem[r]; s_mem[r] = t;
    end
    ct_mem[0] = 8'd255;
    for (int a = 1; a < 256; a++) ct_mem[a] = byte_t'($urandom);
    ms = s_mem;
    model_run();
    run_msg(1'b0, busy);
    check("len255_busy", 32'(busy), 32'd1277);
    for (int a = 0; a < 256; a++) check("len255_pt", pt_mem[a], mpt[a]);
    for (int a = 0; a < 256; a++) check("len255_s", s_mem[a], ms[a]);

    // Reset in the middle of a run
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (100) @(negedge clk);
    check("midrun_busy", rdy, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rdy", rdy, 32'd1);
    check("midrst_s_wren", s_wren, 32'd0);
    check("midrst_pt_wren", pt_wren, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_idle", rdy, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
